// File: rtl/write_back_pkg.sv
// Shared core definitions: data width, register count, load funct3 codes, stage FSM states.
package write_back_pkg;

   localparam int unsigned XLEN   = 64;
   localparam int unsigned NREGS  = 32;
   localparam int unsigned REG_AW = 5;

   // Load funct3 codes
   localparam logic [2:0] LD_LB  = 3'd0;
   localparam logic [2:0] LD_LH  = 3'd1;
   localparam logic [2:0] LD_LW  = 3'd2;
   localparam logic [2:0] LD_LD  = 3'd3;
   localparam logic [2:0] LD_LBU = 3'd4;
   localparam logic [2:0] LD_LHU = 3'd5;
   localparam logic [2:0] LD_LWU = 3'd6;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REDIRECT = 2'd1,
      ST_SQUASH   = 2'd2
   } wb_state_e;

endpackage

// File: rtl/write_back_load_align.sv
// Load lane extraction: selects the addressed lane of the bus doubleword,
// sign/zero extends it, and flags misaligned or illegal load codes.
module write_back_load_align
   import write_back_pkg::*;
(
   input  logic [XLEN-1:0] i_res,
   input  logic [2:0]      i_type,
   input  logic [2:0]      i_off,
   output logic [XLEN-1:0] o_data_c,
   output logic            o_bad_c
);

   logic [XLEN-1:0] w_shift;

   assign w_shift = i_res >> {i_off, 3'b000};

   // Extend the shifted lane and check natural alignment for its width
   always_comb begin
      o_data_c = w_shift;
      o_bad_c  = 1'b0;
      case (i_type)
         LD_LB:  o_data_c = {{56{w_shift[7]}},  w_shift[7:0]};
         LD_LH: begin
            o_data_c = {{48{w_shift[15]}}, w_shift[15:0]};
            o_bad_c  = i_off[0];
         end
         LD_LW: begin
            o_data_c = {{32{w_shift[31]}}, w_shift[31:0]};
            o_bad_c  = |i_off[1:0];
         end
         LD_LD: begin
            o_data_c = w_shift;
            o_bad_c  = |i_off;
         end
         LD_LBU: o_data_c = {56'd0, w_shift[7:0]};
         LD_LHU: begin
            o_data_c = {48'd0, w_shift[15:0]};
            o_bad_c  = i_off[0];
         end
         LD_LWU: begin
            o_data_c = {32'd0, w_shift[31:0]};
            o_bad_c  = |i_off[1:0];
         end
         default: o_bad_c = 1'b1;
      endcase
   end

endmodule

// File: rtl/write_back.sv
// Write-back stage: load extraction, register file commit with read bypass,
// branch redirect plus squash window, and retired-instruction counter.
module write_back
   import write_back_pkg::*;
#(
   parameter int unsigned SQUASH_CYCLES = 2
)(
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [XLEN-1:0]   res_i,
   input  logic [REG_AW-1:0] rd_i,
   input  logic              wb_en_i,
   input  logic              load_i,
   input  logic [2:0]        load_type_i,
   input  logic [2:0]        byte_off_i,
   input  logic              take_branch_i,
   input  logic [XLEN-1:0]   branch_offset_i,
   input  logic [XLEN-1:0]   PC_i,
   input  logic [REG_AW-1:0] rs1_addr_i,
   input  logic [REG_AW-1:0] rs2_addr_i,
   output logic [XLEN-1:0]   rs1_data_o,
   output logic [XLEN-1:0]   rs2_data_o,
   output logic              redirect_o,
   output logic [XLEN-1:0]   redirect_pc_o,
   output logic              squash_o,
   output logic              misalign_o,
   output logic [XLEN-1:0]   retired_o
);

   localparam int unsigned CNT_W = 3;

   wb_state_e        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_redirect;
   logic [XLEN-1:0]  r_redirect_pc;
   logic             r_squash;
   logic             r_misalign;
   logic [XLEN-1:0]  r_retired;
   logic [XLEN-1:0]  r_regs [NREGS];

   logic [XLEN-1:0]  w_ld_data;
   logic             w_ld_bad;
   logic [XLEN-1:0]  w_wdata;
   logic             w_idle;
   logic             w_commit;
   logic             w_take;
   logic             w_retire;

   write_back_load_align u_load_align (
      .i_res    (res_i),
      .i_type   (load_type_i),
      .i_off    (byte_off_i),
      .o_data_c (w_ld_data),
      .o_bad_c  (w_ld_bad)
   );

   // Only IDLE accepts input; REDIRECT and SQUASH discard everything
   assign w_idle   = (r_state == ST_IDLE);
   assign w_wdata  = load_i ? w_ld_data : res_i;
   assign w_commit = w_idle && wb_en_i && !(load_i && w_ld_bad);
   assign w_take   = w_idle && take_branch_i;
   assign w_retire = w_commit || w_take;

   // Register file write; x0 is never written
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         for (int i = 0; i < int'(NREGS); i++) r_regs[i] <= '0;
      end else if (w_commit && (rd_i != '0)) begin
         r_regs[rd_i] <= w_wdata;
      end
   end

   // Read ports with x0 forced to zero and same-cycle commit bypass
   always_comb begin
      rs1_data_o = r_regs[rs1_addr_i];
      rs2_data_o = r_regs[rs2_addr_i];
      if (rs1_addr_i == '0)                         rs1_data_o = '0;
      else if (w_commit && (rd_i == rs1_addr_i))    rs1_data_o = w_wdata;
      if (rs2_addr_i == '0)                         rs2_data_o = '0;
      else if (w_commit && (rd_i == rs2_addr_i))    rs2_data_o = w_wdata;
   end

   // Redirect/squash FSM, misalign pulse and retire counter
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_redirect    <= 1'b0;
         r_redirect_pc <= '0;
         r_squash      <= 1'b0;
         r_misalign    <= 1'b0;
         r_retired     <= '0;
      end else begin
         r_redirect <= 1'b0;
         r_misalign <= w_idle && load_i && w_ld_bad;
         if (w_retire) r_retired <= r_retired + XLEN'(1);
         case (r_state)
            ST_IDLE: begin
               if (take_branch_i) begin
                  r_state       <= ST_REDIRECT;
                  r_redirect    <= 1'b1;
                  r_redirect_pc <= PC_i + branch_offset_i;
                  r_squash      <= 1'b1;
               end
            end
            ST_REDIRECT: begin
               if (SQUASH_CYCLES > 1) begin
                  r_state  <= ST_SQUASH;
                  r_cnt    <= CNT_W'(SQUASH_CYCLES - 1);
                  r_squash <= 1'b1;
               end else begin
                  r_state  <= ST_IDLE;
                  r_squash <= 1'b0;
               end
            end
            ST_SQUASH: begin
               if (r_cnt <= CNT_W'(1)) begin
                  r_state  <= ST_IDLE;
                  r_cnt    <= '0;
                  r_squash <= 1'b0;
               end else begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end
            end
            default: begin
               r_state  <= ST_IDLE;
               r_cnt    <= '0;
               r_squash <= 1'b0;
            end
         endcase
      end
   end

   assign redirect_o    = r_redirect;
   assign redirect_pc_o = r_redirect_pc;
   assign squash_o      = r_squash;
   assign misalign_o    = r_misalign;
   assign retired_o     = r_retired;

endmodule

// File: tb/tb_write_back.sv
// Bench for write_back: directed vector table, reset-during-squash sequence,
// and randomized traffic against a behavioural model.
module tb_write_back;
   import write_back_pkg::*;

   localparam int unsigned SQ = 2;

   logic        CLK;
   logic        RST_N;
   logic [63:0] res_i;
   logic [4:0]  rd_i;
   logic        wb_en_i;
   logic        load_i;
   logic [2:0]  load_type_i;
   logic [2:0]  byte_off_i;
   logic        take_branch_i;
   logic [63:0] branch_offset_i;
   logic [63:0] PC_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic [63:0] rs1_data_o;
   logic [63:0] rs2_data_o;
   logic        redirect_o;
   logic [63:0] redirect_pc_o;
   logic        squash_o;
   logic        misalign_o;
   logic [63:0] retired_o;

   write_back #(.SQUASH_CYCLES(SQ)) dut (
      .CLK(CLK), .RST_N(RST_N), .res_i(res_i), .rd_i(rd_i), .wb_en_i(wb_en_i),
      .load_i(load_i), .load_type_i(load_type_i), .byte_off_i(byte_off_i),
      .take_branch_i(take_branch_i), .branch_offset_i(branch_offset_i), .PC_i(PC_i),
      .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
      .rs1_data_o(rs1_data_o), .rs2_data_o(rs2_data_o),
      .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o), .squash_o(squash_o),
      .misalign_o(misalign_o), .retired_o(retired_o)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rd;
      logic        wb;
      logic        ld;
      logic [2:0]  lt;
      logic [2:0]  off;
      logic        tk;
      logic [63:0] pc;
      logic [63:0] boff;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [63:0] e1;
      logic [63:0] e2;
      logic        e_redir;
      logic [63:0] e_pc;
      logic        e_sq;
      logic        e_mis;
      logic [63:0] e_ret;
   } vec_t;

   vec_t tbl [12];

   int n_vec = 0;
   int n_err = 0;

   // behavioural model state
   logic [63:0] m_regs [32];
   logic [63:0] m_ret;
   logic [63:0] m_pc;
   logic        m_redir;
   logic        m_mis;
   int          m_left;

   function automatic vec_t mk(
      input logic [63:0] res, input logic [4:0] rd, input logic wb, input logic ld,
      input logic [2:0] lt, input logic [2:0] off, input logic tk,
      input logic [63:0] pc, input logic [63:0] boff,
      input logic [4:0] a1, input logic [4:0] a2,
      input logic [63:0] e1, input logic [63:0] e2,
      input logic e_redir, input logic [63:0] e_pc, input logic e_sq,
      input logic e_mis, input logic [63:0] e_ret);
      vec_t v;
      v.res = res; v.rd = rd; v.wb = wb; v.ld = ld; v.lt = lt; v.off = off;
      v.tk = tk; v.pc = pc; v.boff = boff; v.a1 = a1; v.a2 = a2;
      v.e1 = e1; v.e2 = e2; v.e_redir = e_redir; v.e_pc = e_pc;
      v.e_sq = e_sq; v.e_mis = e_mis; v.e_ret = e_ret;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   task automatic drive(input logic [63:0] res, input logic [4:0] rd, input logic wb,
                        input logic ld, input logic [2:0] lt, input logic [2:0] off,
                        input logic tk, input logic [63:0] pc, input logic [63:0] boff,
                        input logic [4:0] a1, input logic [4:0] a2);
      res_i = res; rd_i = rd; wb_en_i = wb; load_i = ld; load_type_i = lt;
      byte_off_i = off; take_branch_i = tk; PC_i = pc; branch_offset_i = boff;
      rs1_addr_i = a1; rs2_addr_i = a2;
   endtask

   // Reference load: {illegal, value} from width/signedness rules
   function automatic logic [64:0] m_load(input logic [63:0] res, input logic [2:0] lt,
                                          input logic [2:0] off);
      int w;
      bit sgn;
      bit bad;
      logic [63:0] lane;
      logic [63:0] mask;
      bad = 1'b0;
      case (lt)
         3'd0: begin w = 8;  sgn = 1; end
         3'd1: begin w = 16; sgn = 1; end
         3'd2: begin w = 32; sgn = 1; end
         3'd3: begin w = 64; sgn = 1; end
         3'd4: begin w = 8;  sgn = 0; end
         3'd5: begin w = 16; sgn = 0; end
         3'd6: begin w = 32; sgn = 0; end
         default: begin w = 8; sgn = 0; bad = 1'b1; end
      endcase
      if ((int'(off) % (w / 8)) != 0) bad = 1'b1;
      lane = res >> (8 * int'(off));
      if (w < 64) begin
         mask = (64'd1 << w) - 64'd1;
         lane = lane & mask;
         if (sgn && lane[w-1]) lane = lane | ~mask;
      end
      return {bad, lane};
   endfunction

   task automatic m_reset();
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_ret = '0; m_pc = '0; m_redir = 1'b0; m_mis = 1'b0; m_left = 0;
   endtask

   // One cycle of model + checks: reads before the edge, registered outputs after
   task automatic model_cycle();
      logic [64:0] lr;
      logic        active, bad, commit, take;
      logic [63:0] wdata, e1, e2;
      active = (m_left == 0);
      lr     = m_load(res_i, load_type_i, byte_off_i);
      bad    = lr[64];
      wdata  = load_i ? lr[63:0] : res_i;
      commit = active && wb_en_i && !(load_i && bad);
      take   = active && take_branch_i;
      e1 = (rs1_addr_i == 0) ? 64'd0 : (commit && rd_i == rs1_addr_i) ? wdata : m_regs[rs1_addr_i];
      e2 = (rs2_addr_i == 0) ? 64'd0 : (commit && rd_i == rs2_addr_i) ? wdata : m_regs[rs2_addr_i];
      #1;
      chk("rnd_rs1", rs1_data_o, e1);
      chk("rnd_rs2", rs2_data_o, e2);
      @(posedge CLK);
      #1;
      m_redir = take;
      if (take) m_pc = PC_i + branch_offset_i;
      m_mis = active && load_i && bad;
      if (commit || take) m_ret = m_ret + 64'd1;
      if (commit && rd_i != 0) m_regs[rd_i] = wdata;
      if (take) m_left = SQ;
      else if (m_left > 0) m_left--;
      chk("rnd_redirect", {63'd0, redirect_o}, {63'd0, m_redir});
      chk("rnd_redirect_pc", redirect_pc_o, m_pc);
      chk("rnd_squash", {63'd0, squash_o}, {63'd0, m_left > 0});
      chk("rnd_misalign", {63'd0, misalign_o}, {63'd0, m_mis});
      chk("rnd_retired", retired_o, m_ret);
   endtask

   initial begin
      logic [63:0] lb;
      lb = 64'h8877_6655_4433_2211;
      // ALU commits, loads, misaligned/illegal loads, x0, then branch + squash window
      tbl[0]  = mk(64'h1234, 5, 1, 0, 0, 0, 0, 0, 0, 5, 0, 64'h1234, 0, 0, 0, 0, 0, 1);
      tbl[1]  = mk(lb, 6, 1, 1, 0, 7, 0, 0, 0, 6, 5, 64'hFFFF_FFFF_FFFF_FF88, 64'h1234, 0, 0, 0, 0, 2);
      tbl[2]  = mk(lb, 7, 1, 1, 6, 4, 0, 0, 0, 7, 6, 64'h8877_6655, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 0, 0, 3);
      tbl[3]  = mk(lb, 8, 1, 1, 1, 2, 0, 0, 0, 8, 7, 64'h4433, 64'h8877_6655, 0, 0, 0, 0, 4);
      tbl[4]  = mk(lb, 9, 1, 1, 2, 2, 0, 0, 0, 9, 8, 0, 64'h4433, 0, 0, 0, 1, 4);
      tbl[5]  = mk(lb, 9, 1, 1, 7, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 1, 4);
      tbl[6]  = mk(64'hDEAD, 0, 1, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 0, 0, 0, 0, 5);
      tbl[7]  = mk(64'h1004, 1, 1, 0, 0, 0, 1, 64'h1000, 64'hFFFF_FFFF_FFFF_FFF0, 1, 5,
                   64'h1004, 64'h1234, 1, 64'hFF0, 1, 0, 6);
      tbl[8]  = mk(64'hAAAA, 10, 1, 0, 0, 0, 0, 0, 0, 10, 1, 0, 64'h1004, 0, 64'hFF0, 1, 0, 6);
      tbl[9]  = mk(64'hBBBB, 11, 1, 0, 0, 0, 1, 64'h5000, 64'h8, 11, 10, 0, 0, 0, 64'hFF0, 0, 0, 6);
      tbl[10] = mk(64'hCCCC, 12, 1, 0, 0, 0, 0, 0, 0, 12, 10, 64'hCCCC, 0, 0, 64'hFF0, 0, 0, 7);
      tbl[11] = mk(lb, 13, 1, 1, 3, 0, 0, 0, 0, 11, 12, 0, 64'hCCCC, 0, 64'hFF0, 0, 0, 8);

      // Reset state
      RST_N = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0);
      #12;
      chk("reset_redirect", {63'd0, redirect_o}, 64'd0);
      chk("reset_pc", redirect_pc_o, 64'd0);
      chk("reset_squash", {63'd0, squash_o}, 64'd0);
      chk("reset_misalign", {63'd0, misalign_o}, 64'd0);
      chk("reset_retired", retired_o, 64'd0);
      chk("reset_rs1", rs1_data_o, 64'd0);
      RST_N = 1'b1;

      // Directed vector table
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].res, tbl[i].rd, tbl[i].wb, tbl[i].ld, tbl[i].lt, tbl[i].off,
               tbl[i].tk, tbl[i].pc, tbl[i].boff, tbl[i].a1, tbl[i].a2);
         #1;
         chk($sformatf("tbl%0d_rs1", i), rs1_data_o, tbl[i].e1);
         chk($sformatf("tbl%0d_rs2", i), rs2_data_o, tbl[i].e2);
         @(posedge CLK);
         #1;
         chk($sformatf("tbl%0d_redirect", i), {63'd0, redirect_o}, {63'd0, tbl[i].e_redir});
         chk($sformatf("tbl%0d_redirect_pc", i), redirect_pc_o, tbl[i].e_pc);
         chk($sformatf("tbl%0d_squash", i), {63'd0, squash_o}, {63'd0, tbl[i].e_sq});
         chk($sformatf("tbl%0d_misalign", i), {63'd0, misalign_o}, {63'd0, tbl[i].e_mis});
         chk($sformatf("tbl%0d_retired", i), retired_o, tbl[i].e_ret);
      end

      // Async reset while in SQUASH, then a fresh branch
      drive(64'h33, 3, 1, 0, 0, 0, 1, 64'h2000, 64'h10, 0, 0);
      @(posedge CLK); #1;
      chk("rst_seq_redirect", {63'd0, redirect_o}, 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 3);
      @(posedge CLK); #1;
      chk("rst_seq_squash_before", {63'd0, squash_o}, 64'd1);
      #3;
      RST_N = 1'b0;
      #1;
      chk("rst_seq_squash", {63'd0, squash_o}, 64'd0);
      chk("rst_seq_redirect_pc", redirect_pc_o, 64'd0);
      chk("rst_seq_retired", retired_o, 64'd0);
      chk("rst_seq_rs1_cleared", rs1_data_o, 64'd0);
      chk("rst_seq_rs2_cleared", rs2_data_o, 64'd0);
      @(negedge CLK);
      RST_N = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 1, 64'h100, 64'h20, 0, 0);
      @(posedge CLK); #1;
      chk("post_rst_redirect", {63'd0, redirect_o}, 64'd1);
      chk("post_rst_pc", redirect_pc_o, 64'h120);
      chk("post_rst_retired", retired_o, 64'd1);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk("post_rst_pulse_width", {63'd0, redirect_o}, 64'd0);

      // Randomized traffic against the model
      RST_N = 1'b0;
      #2;
      RST_N = 1'b1;
      m_reset();
      for (int c = 0; c < 400; c++) begin
         logic [4:0] rd;
         logic [2:0] off;
         rd  = 5'($urandom_range(0, 31));
         off = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 1) == 0) off = off & 3'($urandom_range(0, 7) & 4);
         drive({$urandom, $urandom}, rd, $urandom_range(0, 9) < 8,
               $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), off,
               $urandom_range(0, 11) == 0, {$urandom, $urandom}, {$urandom, $urandom},
               ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31)),
               5'($urandom_range(0, 31)));
         model_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
